// File: rtl/mdio_arbiter.sv
// -----------------------------------------------------------------------------
// mdio_arbiter
//   Round-robin arbiter that shares one MDIO driver operation port between two
//   independent clients (for example a PHY init sequencer and a link poller).
//   Transactions are serialised one at a time. Each client gets its own
//   response: read data, the driver's raw ack bit, and a timeout flag that is
//   set when the driver never reports completion.
//
// Ports
//   clk, rst_n              driver clock, asynchronous active-low reset
//   reqN_valid/ready        client N request handshake (ready is combinational)
//   reqN_rh_wl/addr/wr_data client N op type (1=read), register addr, wr data
//   rspN_valid              client N one-cycle response strobe
//   rspN_rd_data/rd_ack     client N captured read data / driver ack
//   rspN_timeout            client N transaction aborted by timeout
//   op_exec/op_rh_wl/op_addr/op_wr_data   request towards the MDIO driver
//   op_done/op_rd_data/op_rd_ack          completion from the MDIO driver
//   busy                    high whenever a transaction is in progress
// -----------------------------------------------------------------------------
module mdio_arbiter #(
    parameter logic [15:0] TIMEOUT = 16'd2000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req0_rh_wl,
    input  logic [4:0]  req0_addr,
    input  logic [15:0] req0_wr_data,
    output logic        rsp0_valid,
    output logic [15:0] rsp0_rd_data,
    output logic        rsp0_rd_ack,
    output logic        rsp0_timeout,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        req1_rh_wl,
    input  logic [4:0]  req1_addr,
    input  logic [15:0] req1_wr_data,
    output logic        rsp1_valid,
    output logic [15:0] rsp1_rd_data,
    output logic        rsp1_rd_ack,
    output logic        rsp1_timeout,
    output logic        op_exec,
    output logic        op_rh_wl,
    output logic [4:0]  op_addr,
    output logic [15:0] op_wr_data,
    input  logic        op_done,
    input  logic [15:0] op_rd_data,
    input  logic        op_rd_ack,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        rr_ptr;
    logic        owner;
    logic        grant;
    logic        accept;
    logic        expire;
    logic        finish;
    logic [15:0] to_cnt;
    logic [15:0] fin_data;
    logic        fin_ack;

    // Contention is resolved by rr_ptr; a lone requester always wins.
    assign grant  = (req0_valid && req1_valid) ? rr_ptr : req1_valid;
    assign accept = (state == IDLE) && (req0_valid || req1_valid);

    // op_done has priority over expiry when both land in the same cycle.
    assign expire = (to_cnt == (TIMEOUT - 16'd1));
    assign finish = (state == WAIT) && (op_done || expire);

    // A timeout reports zero data with the ack bit set (no PHY answered).
    assign fin_data = op_done ? op_rd_data : 16'h0000;
    assign fin_ack  = op_done ? op_rd_ack  : 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (op_done || expire) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        op_exec    = (state == ISSUE);
        busy       = (state != IDLE);
        req0_ready = (state == IDLE) && !grant && req0_valid;
        req1_ready = (state == IDLE) &&  grant && req1_valid;
    end

    // Request capture, round-robin pointer and timeout counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr     <= 1'b0;
            owner      <= 1'b0;
            to_cnt     <= 16'd0;
            op_rh_wl   <= 1'b0;
            op_addr    <= 5'd0;
            op_wr_data <= 16'd0;
        end else begin
            if (accept) begin
                owner      <= grant;
                rr_ptr     <= ~grant;
                op_rh_wl   <= grant ? req1_rh_wl   : req0_rh_wl;
                op_addr    <= grant ? req1_addr    : req0_addr;
                op_wr_data <= grant ? req1_wr_data : req0_wr_data;
            end
            if (state == ISSUE) begin
                to_cnt <= 16'd0;
            end else if (state == WAIT && !op_done && !expire) begin
                to_cnt <= to_cnt + 16'd1;
            end
        end
    end

    // Response registers: written only for the owner, held until its next RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp0_valid   <= 1'b0;
            rsp0_rd_data <= 16'd0;
            rsp0_rd_ack  <= 1'b0;
            rsp0_timeout <= 1'b0;
            rsp1_valid   <= 1'b0;
            rsp1_rd_data <= 16'd0;
            rsp1_rd_ack  <= 1'b0;
            rsp1_timeout <= 1'b0;
        end else begin
            rsp0_valid <= finish && !owner;
            rsp1_valid <= finish &&  owner;
            if (finish && !owner) begin
                rsp0_rd_data <= fin_data;
                rsp0_rd_ack  <= fin_ack;
                rsp0_timeout <= !op_done;
            end
            if (finish && owner) begin
                rsp1_rd_data <= fin_data;
                rsp1_rd_ack  <= fin_ack;
                rsp1_timeout <= !op_done;
            end
        end
    end

endmodule

// File: tb/tb_mdio_arbiter.sv
module tb_mdio_arbiter;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 0, req0_rh_wl = 0;
    logic [4:0]  req0_addr = 0;
    logic [15:0] req0_wr_data = 0;
    logic        req1_valid = 0, req1_rh_wl = 0;
    logic [4:0]  req1_addr = 0;
    logic [15:0] req1_wr_data = 0;
    logic        req0_ready, req1_ready;
    logic        rsp0_valid, rsp0_rd_ack, rsp0_timeout;
    logic        rsp1_valid, rsp1_rd_ack, rsp1_timeout;
    logic [15:0] rsp0_rd_data, rsp1_rd_data;
    logic        op_exec, op_rh_wl, busy;
    logic [4:0]  op_addr;
    logic [15:0] op_wr_data;
    logic        op_done = 0, op_rd_ack = 0;
    logic [15:0] op_rd_data = 0;

    mdio_arbiter #(.TIMEOUT(16'(TO))) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_rh_wl(req0_rh_wl),
        .req0_addr(req0_addr), .req0_wr_data(req0_wr_data),
        .rsp0_valid(rsp0_valid), .rsp0_rd_data(rsp0_rd_data),
        .rsp0_rd_ack(rsp0_rd_ack), .rsp0_timeout(rsp0_timeout),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_rh_wl(req1_rh_wl),
        .req1_addr(req1_addr), .req1_wr_data(req1_wr_data),
        .rsp1_valid(rsp1_valid), .rsp1_rd_data(rsp1_rd_data),
        .rsp1_rd_ack(rsp1_rd_ack), .rsp1_timeout(rsp1_timeout),
        .op_exec(op_exec), .op_rh_wl(op_rh_wl), .op_addr(op_addr),
        .op_wr_data(op_wr_data), .op_done(op_done), .op_rd_data(op_rd_data),
        .op_rd_ack(op_rd_ack), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state: round-robin pointer and last response per client.
    bit          m_rr;
    logic [15:0] m_data [2];
    logic        m_ack  [2];
    logic        m_to   [2];

    // Fields for the next transaction.
    logic        f_rh   [2];
    logic [4:0]  f_addr [2];
    logic [15:0] f_wd   [2];
    logic [15:0] f_d;
    logic        f_a;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_fields();
        for (int i = 0; i < 2; i++) begin
            f_rh[i]   = 1'($urandom);
            f_addr[i] = 5'($urandom);
            f_wd[i]   = 16'($urandom);
        end
        f_d = 16'($urandom);
        f_a = 1'($urandom);
    endtask

    task automatic model_reset();
        m_rr = 0;
        for (int i = 0; i < 2; i++) begin
            m_data[i] = 0; m_ack[i] = 0; m_to[i] = 0;
        end
    endtask

    task automatic chk_rsp_regs(input string tag);
        chk({tag, "_d0"},  rsp0_rd_data, m_data[0]);
        chk({tag, "_a0"},  rsp0_rd_ack,  m_ack[0]);
        chk({tag, "_t0"},  rsp0_timeout, m_to[0]);
        chk({tag, "_d1"},  rsp1_rd_data, m_data[1]);
        chk({tag, "_a1"},  rsp1_rd_ack,  m_ack[1]);
        chk({tag, "_t1"},  rsp1_timeout, m_to[1]);
    endtask

    // One transaction starting in an IDLE cycle. j = WAIT cycle on which the
    // driver pulses op_done (1..TO), or 0 for a driver that never answers.
    // keep = leave both valids asserted after acceptance.
    task automatic txn(input bit v0, input bit v1, input bit keep, input int j);
        bit g;
        int rsp_c;
        g = (v0 && v1) ? m_rr : v1;
        req0_valid = v0; req0_rh_wl = f_rh[0]; req0_addr = f_addr[0]; req0_wr_data = f_wd[0];
        req1_valid = v1; req1_rh_wl = f_rh[1]; req1_addr = f_addr[1]; req1_wr_data = f_wd[1];
        #1;
        chk("ready0", req0_ready, v0 && !g);
        chk("ready1", req1_ready, v1 && g);
        chk("busy_idle", busy, 0);
        tick();
        m_rr = ~g;
        if (!keep) begin
            req0_valid = 0; req1_valid = 0;
        end
        chk("op_exec", op_exec, 1);
        chk("op_rh_wl", op_rh_wl, f_rh[g]);
        chk("op_addr", op_addr, f_addr[g]);
        chk("op_wr_data", op_wr_data, f_wd[g]);
        chk("busy_issue", busy, 1);
        chk("ready_issue", {req0_ready, req1_ready}, 0);
        rsp_c = (j == 0) ? TO + 1 : j + 1;
        for (int c = 1; c <= rsp_c; c++) begin
            tick();
            if (c < rsp_c) begin
                op_done    = (c == j);
                op_rd_data = (c == j) ? f_d : 16'($urandom);
                op_rd_ack  = (c == j) ? f_a : 1'($urandom);
                chk("exec_wait", op_exec, 0);
                chk("rsp_early", {rsp0_valid, rsp1_valid}, 0);
                chk("ready_wait", {req0_ready, req1_ready}, 0);
                chk("busy_wait", busy, 1);
            end else begin
                op_done = 0;
                m_data[g] = (j == 0) ? 16'h0 : f_d;
                m_ack[g]  = (j == 0) ? 1'b1  : f_a;
                m_to[g]   = (j == 0);
                chk("rsp0_valid", rsp0_valid, !g);
                chk("rsp1_valid", rsp1_valid, g);
                chk_rsp_regs("rsp");
                chk("op_addr_hold", op_addr, f_addr[g]);
                chk("busy_resp", busy, 1);
            end
        end
        tick();
        chk("rsp_after", {rsp0_valid, rsp1_valid}, 0);
        chk("busy_after", busy, 0);
    endtask

    initial begin
        model_reset();
        #2;
        chk("rst_outs", {op_exec, op_rh_wl, op_addr, op_wr_data, busy,
                         rsp0_valid, rsp0_rd_data, rsp0_rd_ack, rsp0_timeout}, 0);
        chk("rst_outs1", {rsp1_valid, rsp1_rd_data, rsp1_rd_ack, rsp1_timeout}, 0);
        #10 rst_n = 1;
        tick();

        // Single read from client 0.
        rand_fields();
        f_rh[0] = 1; f_addr[0] = 5'h02; f_d = 16'h0141; f_a = 0;
        txn(1, 0, 0, 3);

        // Write from client 1.
        rand_fields();
        f_rh[1] = 0; f_addr[1] = 5'h00; f_wd[1] = 16'h9140;
        txn(0, 1, 0, 4);

        // Continuous contention: grants must alternate.
        for (int k = 0; k < 4; k++) begin
            rand_fields();
            txn(1, 1, (k < 3), $urandom_range(1, 6));
        end

        // Timeout, then a late op_done in IDLE must be ignored.
        rand_fields();
        txn(1, 0, 0, 0);
        op_done = 1; op_rd_data = 16'hdead; op_rd_ack = 0;
        tick();
        op_done = 0;
        chk("late_rsp", {rsp0_valid, rsp1_valid}, 0);
        chk("late_busy", busy, 0);
        tick();
        chk("late_rsp2", {rsp0_valid, rsp1_valid}, 0);
        chk_rsp_regs("late");

        // op_done on the final WAIT cycle beats expiry.
        rand_fields();
        txn(0, 1, 0, TO);

        // Randomized traffic.
        for (int k = 0; k < 30; k++) begin
            int sel;
            int j;
            rand_fields();
            sel = $urandom_range(1, 3);
            j   = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, TO);
            txn(sel[0], sel[1], 0, j);
        end

        // Reset while waiting on the driver.
        req1_valid = 1; req1_rh_wl = 1; req1_addr = 5'h0a; req1_wr_data = 16'h1234;
        #1;
        chk("rw_ready1", req1_ready, !req0_valid);
        tick();
        req1_valid = 0;
        chk("rw_exec", op_exec, 1);
        tick();
        tick();
        chk("rw_busy", busy, 1);
        #2 rst_n = 0;
        #1;
        model_reset();
        chk("rw_outs", {op_exec, op_rh_wl, op_addr, op_wr_data, busy,
                        rsp0_valid, rsp1_valid}, 0);
        chk_rsp_regs("rw");
        op_done = 1;
        tick();
        chk("rw_busy_rst", busy, 0);
        #2 rst_n = 1;
        op_done = 0;
        tick();
        chk("rw_norsp", {rsp0_valid, rsp1_valid}, 0);
        tick();
        chk("rw_norsp2", {rsp0_valid, rsp1_valid, busy}, 0);

        // After reset: lone client 1 wins, then contention goes to client 0.
        rand_fields();
        txn(0, 1, 0, 5);
        rand_fields();
        txn(1, 1, 0, 3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
